shift_arbiter: RTL
==================

Name: shift_arbiter

Overview:
- Shares one combinational WIDTH-bit logical barrel-shift datapath between two requesters (port 0, port 1).
- Requests arrive on valid/ready channels; round-robin arbitration grants one per cycle.
- The shifted result is captured in a single-entry output register, with a requester ID and a valid/ready handshake toward the consumer.
- Sits between the ALU-side request sources and the writeback stage.

Parameters:
- WIDTH, 8, data width; must be a power of two, 2 or greater.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low
- req0_valid  input  1  requester 0 has a request
- req0_ready  output  1  requester 0 request accepted this cycle
- req0_data  input  WIDTH  operand
- req0_amt  input  SHW  shift amount, 0..WIDTH-1
- req0_dir  input  1  0 = left, 1 = right
- req1_valid, req1_ready, req1_data, req1_amt, req1_dir: same as port 0, for requester 1
- req0_rot, req1_rot  input  1  rotate select; present only with ROTATE_EN
- out_valid  output  1  result register holds a valid result
- out_ready  input  1  consumer accepts the result
- out_data  output  WIDTH  shifted result
- out_id  output  1  requester that produced out_data
- busy  output  1  equals out_valid

Behaviour:
- Single clock clk; reset rst_n is synchronous, active-low, sampled on rising clk.
- Reset values: out_valid=0, out_data=0, out_id=0, rr_ptr=0 (requester 0 has first priority). req*_ready is combinational and 0 while out_valid=0 with no requests.
- Shift datapath:
  - dir=0: logical left, zero fill.
  - dir=1: logical right, zero fill.
  - amt=0 passes data unchanged.
  - Result is truncated to WIDTH bits.
- Load condition: can_load = !out_valid || out_ready.
- Arbitration is evaluated combinationally every cycle:
  - Only req0_valid: grant 0.
  - Only req1_valid: grant 1.
  - Both valid: grant rr_ptr.
  - Neither valid: no grant.
- Ready: reqN_ready = can_load && (grant == N). The non-granted requester sees ready=0.
- Load edge (can_load and a grant exists):
  - out_data <= shift(granted operands); out_id <= grant; out_valid <= 1.
  - rr_ptr <= ~grant.
- States are implied by out_valid:
  - EMPTY (out_valid=0): any grant loads; goes to FULL.
  - FULL (out_valid=1):
    - out_ready=0: hold out_data and out_id stable; no grant.
    - out_ready=1 with a grant: drain and reload in the same edge; stay FULL.
    - out_ready=1 without a grant: go to EMPTY; out_data keeps its last value.
- Latency: accept at edge N gives out_valid=1 from edge N onward. Sustained throughput is 1 per cycle when out_ready is held 1.
- Requesters must hold data/amt/dir stable while valid=1 and ready=0. Dropping valid before ready is permitted, and nothing is captured.
- Fairness: under continuous dual requests, grants strictly alternate 0,1,0,1.
- Reset asserted mid-transaction: the result is discarded; all state returns to reset values on that edge. No ready is asserted while rst_n=0.
- rr_ptr changes only on a load edge.

Optional Feature:
- Macro: SHIFT_ARB_ROTATE_EN.
- Defined:
  - req0_rot and req1_rot ports exist.
  - rot=1 makes the shift circular: left rotate when dir=0, right rotate when dir=1. Bits shifted out re-enter at the opposite end.
  - rot=0 is identical to the logical shift.
- Undefined:
  - Rot ports are absent.
  - The datapath is logical-shift only; no rotate logic is synthesized.

Test Plan:
- Reset, then req0 only, data=0xB3, dir=0, amt=1 -> req0_ready=1, next cycle out_valid=1, out_data=0x66, out_id=0.
- req1 only, 0xB3: dir=0 amt=3 -> 0x98; dir=1 amt=2 -> 0x2C; dir=1 amt=4 -> 0x0B; amt=0 -> 0xB3. Each with out_id=1.
- Both requesters valid continuously (req0 0x0F left 4, req1 0xF0 right 4), out_ready=1 -> out_data alternates 0xF0 (id 0) and 0x0F (id 1) every cycle, starting with id 0 after reset.
- out_ready=0 for 3 cycles while FULL with both requesting -> out_data/out_id frozen, both ready=0. Then out_ready=1 -> drain and reload the same cycle, no bubble.
- rst_n=0 asserted while out_valid=1 and out_ready=0 -> next edge out_valid=0, out_data=0, rr_ptr=0, no ready during reset.
- With SHIFT_ARB_ROTATE_EN, 0xB3 rot=1: dir=0 amt=1 -> 0x67; dir=1 amt=2 -> 0xEC. With rot=0 -> 0x66 and 0x2C.

Source files
------------

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - two-port round-robin arbiter sharing one barrel shifter, single-entry result register
// Optional circular shift: define SHIFT_ARB_ROTATE_EN to add req0_rot/req1_rot ports.
module shift_arbiter #(
    parameter int WIDTH = 8,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [SHW-1:0]   req0_amt,
    input  logic             req0_dir,
`ifdef SHIFT_ARB_ROTATE_EN
    input  logic             req0_rot,
    input  logic             req1_rot,
`endif
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [SHW-1:0]   req1_amt,
    input  logic             req1_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_id,
    output logic             busy
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_id_q, out_id_d;
    logic             rr_ptr_q, rr_ptr_d;

    logic             grant_valid;
    logic             grant_id;
    logic             can_load;
    logic             load;
    logic [WIDTH-1:0] sel_data;
    logic [SHW-1:0]   sel_amt;
    logic             sel_dir;
    logic [WIDTH-1:0] shift_res;

    function automatic logic [WIDTH-1:0] lshift(input logic [WIDTH-1:0] d,
                                                input logic [SHW-1:0]   a,
                                                input logic             dir);
        lshift = dir ? (d >> a) : (d << a);
    endfunction

`ifdef SHIFT_ARB_ROTATE_EN
    logic sel_rot;

    // Rotation via a doubled operand: the wanted bits land in one half after a plain shift.
    function automatic logic [WIDTH-1:0] rshift(input logic [WIDTH-1:0] d,
                                                input logic [SHW-1:0]   a,
                                                input logic             dir);
        logic [2*WIDTH-1:0] dd;
        dd = {d, d};
        if (dir) begin
            dd = dd >> a;
            rshift = dd[WIDTH-1:0];
        end else begin
            dd = dd << a;
            rshift = dd[2*WIDTH-1:WIDTH];
        end
    endfunction
`endif

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        case ({req1_valid, req0_valid})
            2'b01: begin grant_valid = 1'b1; grant_id = 1'b0;     end
            2'b10: begin grant_valid = 1'b1; grant_id = 1'b1;     end
            2'b11: begin grant_valid = 1'b1; grant_id = rr_ptr_q; end
            default: begin grant_valid = 1'b0; grant_id = 1'b0;   end
        endcase
    end

    assign can_load   = !out_valid_q || out_ready;
    assign load       = rst_n && can_load && grant_valid;
    assign req0_ready = load && !grant_id;
    assign req1_ready = load && grant_id;

    assign sel_data = grant_id ? req1_data : req0_data;
    assign sel_amt  = grant_id ? req1_amt  : req0_amt;
    assign sel_dir  = grant_id ? req1_dir  : req0_dir;

`ifdef SHIFT_ARB_ROTATE_EN
    assign sel_rot   = grant_id ? req1_rot : req0_rot;
    assign shift_res = sel_rot ? rshift(sel_data, sel_amt, sel_dir)
                               : lshift(sel_data, sel_amt, sel_dir);
`else
    assign shift_res = lshift(sel_data, sel_amt, sel_dir);
`endif

    // A drain with no new grant empties the register but leaves the data in place.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        rr_ptr_d    = rr_ptr_q;
        if (can_load) begin
            out_valid_d = grant_valid;
        end
        if (load) begin
            out_data_d = shift_res;
            out_id_d   = grant_id;
            rr_ptr_d   = ~grant_id;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= 1'b0;
            rr_ptr_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign busy      = out_valid_q;

endmodule
